// File: rtl/decode_stage_if.sv
// ID/EX bundle: decoded control, operands and immediate handed from decode to execute.
// master drives the registered fields, slave (execute) consumes them.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_rs1_val;
  logic [XLEN-1:0] ex_rs2_val;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic [2:0]      ex_funct3;
  logic [3:0]      ex_alu_ctrl;
  logic            ex_alu_src_pc;
  logic            ex_alu_src_imm;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_branch;
  logic            ex_jump;
  logic [1:0]      ex_result_src;
  logic            ex_illegal;

  modport master (
    output ex_valid, ex_pc, ex_imm, ex_rs1_val, ex_rs2_val, ex_rs1, ex_rs2, ex_rd,
           ex_funct3, ex_alu_ctrl, ex_alu_src_pc, ex_alu_src_imm, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_result_src, ex_illegal
  );
  modport slave (
    input  ex_valid, ex_pc, ex_imm, ex_rs1_val, ex_rs2_val, ex_rs1, ex_rs2, ex_rd,
           ex_funct3, ex_alu_ctrl, ex_alu_src_pc, ex_alu_src_imm, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_result_src, ex_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode with ID/EX register; decoded fields reach ex_* one clk after the instruction is presented.
// Backpressure: id_stall holds fetch and IF/ID for one cycle on a load-use hazard; flush overrides it.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  output logic            id_stall,
  output logic [4:0]      rf_a1,
  output logic [4:0]      rf_a2,
  input  logic [XLEN-1:0] rf_rs1,
  input  logic [XLEN-1:0] rf_rs2,
  input  logic            wb_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  decode_stage_if.master  ex
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [3:0]      alu_ctrl;
    logic            alu_src_pc;
    logic            alu_src_imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic [1:0]      result_src;
    logic            illegal;
  } idex_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [3:0]      alu_op;
  logic            use_rs1;
  logic            use_rs2;
  logic            hazard;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  idex_t           dec;
  idex_t           ex_q;

  assign opcode = if_instr[6:0];
  assign funct3 = if_instr[14:12];
  assign rf_a1  = if_instr[19:15];
  assign rf_a2  = if_instr[24:20];

  assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
  assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
  assign imm_u = {if_instr[31:12], 12'b0};
  assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};

  // Register-file write lands on the same edge we capture, so forward it through.
  function automatic logic [XLEN-1:0] src_val(input logic [4:0] a, input logic [XLEN-1:0] rf,
                                               input logic wr, input logic [4:0] wrd,
                                               input logic [XLEN-1:0] wdat);
    if (a == 5'd0)             return '0;
    else if (wr && (wrd == a)) return wdat;
    else                       return rf;
  endfunction

  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      3'b000: alu_op = (opcode == OP_R && if_instr[30]) ? ALU_SUB : ALU_ADD;
      3'b001: alu_op = ALU_SLL;
      3'b010: alu_op = ALU_SLT;
      3'b011: alu_op = ALU_SLTU;
      3'b100: alu_op = ALU_XOR;
      3'b101: alu_op = if_instr[30] ? ALU_SRA : ALU_SRL;
      3'b110: alu_op = ALU_OR;
      3'b111: alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

  always_comb begin
    dec        = '0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    dec.valid  = 1'b1;
    dec.pc     = if_pc;
    dec.funct3 = funct3;
    case (opcode)
      OP_R: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec.alu_ctrl = alu_op; dec.reg_write = 1'b1;
      end
      OP_I: begin
        use_rs1 = 1'b1;
        dec.imm = imm_i; dec.alu_ctrl = alu_op; dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1;
      end
      OP_LOAD: begin
        use_rs1 = 1'b1;
        dec.imm = imm_i; dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1;
        dec.mem_read = 1'b1; dec.result_src = 2'd1;
      end
      OP_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec.imm = imm_s; dec.alu_src_imm = 1'b1; dec.mem_write = 1'b1;
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec.imm = imm_b; dec.alu_ctrl = ALU_SUB; dec.branch = 1'b1;
      end
      OP_JAL: begin
        dec.imm = imm_j; dec.alu_src_pc = 1'b1; dec.alu_src_imm = 1'b1;
        dec.jump = 1'b1; dec.reg_write = 1'b1; dec.result_src = 2'd2;
      end
      OP_JALR: begin
        use_rs1 = 1'b1;
        dec.imm = imm_i; dec.alu_src_imm = 1'b1;
        dec.jump = 1'b1; dec.reg_write = 1'b1; dec.result_src = 2'd2;
      end
      OP_LUI: begin
        dec.imm = imm_u; dec.alu_ctrl = ALU_PASSB; dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        dec.imm = imm_u; dec.alu_src_pc = 1'b1; dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.rs1     = use_rs1 ? rf_a1 : 5'd0;
    dec.rs2     = use_rs2 ? rf_a2 : 5'd0;
    dec.rd      = dec.reg_write ? if_instr[11:7] : 5'd0;
    dec.rs1_val = src_val(dec.rs1, rf_rs1, wb_write, wb_rd, wb_data);
    dec.rs2_val = src_val(dec.rs2, rf_rs2, wb_write, wb_rd, wb_data);
  end

  assign hazard = if_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                  ((use_rs1 && (rf_a1 == ex_q.rd)) || (use_rs2 && (rf_a2 == ex_q.rd)));
  assign id_stall = hazard && !flush && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          ex_q <= '0;
    else if (flush || hazard || !if_valid) ex_q <= '0;
    else                                ex_q <= dec;
  end

  assign ex.ex_valid       = ex_q.valid;
  assign ex.ex_pc          = ex_q.pc;
  assign ex.ex_imm         = ex_q.imm;
  assign ex.ex_rs1_val     = ex_q.rs1_val;
  assign ex.ex_rs2_val     = ex_q.rs2_val;
  assign ex.ex_rs1         = ex_q.rs1;
  assign ex.ex_rs2         = ex_q.rs2;
  assign ex.ex_rd          = ex_q.rd;
  assign ex.ex_funct3      = ex_q.funct3;
  assign ex.ex_alu_ctrl    = ex_q.alu_ctrl;
  assign ex.ex_alu_src_pc  = ex_q.alu_src_pc;
  assign ex.ex_alu_src_imm = ex_q.alu_src_imm;
  assign ex.ex_reg_write   = ex_q.reg_write;
  assign ex.ex_mem_read    = ex_q.mem_read;
  assign ex.ex_mem_write   = ex_q.mem_write;
  assign ex.ex_branch      = ex_q.branch;
  assign ex.ex_jump        = ex_q.jump;
  assign ex.ex_result_src  = ex_q.result_src;
  assign ex.ex_illegal     = ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed RV32I vectors, expected ID/EX contents queued at issue.
module tb_decode_stage;

  localparam logic [31:0] R1 = 32'h1111_1111;
  localparam logic [31:0] R2 = 32'h2222_2222;
  localparam logic [3:0]  A_ADD = 4'd0, A_SUB = 4'd1, A_SRA = 4'd7, A_PASSB = 4'd10;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [31:0] v1;
    logic [4:0]  rs2;
    logic [31:0] v2;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic [6:0]  f;     // {src_pc, src_imm, reg_write, mem_read, mem_write, branch, jump}
    logic [1:0]  res;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic if_valid = 1'b0, flush = 1'b0, wb_write = 1'b0, id_stall;
  logic [31:0] if_instr = '0, if_pc = '0, rf_rs1 = R1, rf_rs2 = R2, wb_data = '0;
  logic [4:0]  rf_a1, rf_a2, wb_rd = '0;

  int tests = 0;
  int fails = 0;
  exp_t exp_q[$];
  string nm_q[$];
  exp_t me, ma, tmp;
  string mn;

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32)) exb();

  decode_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .flush(flush), .id_stall(id_stall), .rf_a1(rf_a1), .rf_a2(rf_a2),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .wb_write(wb_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex(exb)
  );

  function automatic exp_t act_now();
    exp_t a;
    a.valid = exb.ex_valid;   a.pc = exb.ex_pc;       a.imm = exb.ex_imm;
    a.rs1 = exb.ex_rs1;       a.v1 = exb.ex_rs1_val;  a.rs2 = exb.ex_rs2;
    a.v2 = exb.ex_rs2_val;    a.rd = exb.ex_rd;       a.alu = exb.ex_alu_ctrl;
    a.f = {exb.ex_alu_src_pc, exb.ex_alu_src_imm, exb.ex_reg_write, exb.ex_mem_read,
           exb.ex_mem_write, exb.ex_branch, exb.ex_jump};
    a.res = exb.ex_result_src; a.ill = exb.ex_illegal;
    return a;
  endfunction

  function automatic exp_t mk(input logic [31:0] imm, input logic [4:0] s1, input logic [31:0] v1,
                              input logic [4:0] s2, input logic [31:0] v2, input logic [4:0] rd,
                              input logic [3:0] alu, input logic [6:0] f, input logic [1:0] res,
                              input logic ill);
    exp_t e;
    e.valid = 1'b1; e.pc = '0; e.imm = imm; e.rs1 = s1; e.v1 = v1; e.rs2 = s2; e.v2 = v2;
    e.rd = rd; e.alu = alu; e.f = f; e.res = res; e.ill = ill;
    return e;
  endfunction

  // Called at a falling edge; drives one cycle of ID inputs and returns at the next falling edge.
  task automatic issue(input string nm, input logic [31:0] pc, input logic [31:0] instr,
                       input exp_t e, input logic stall_exp = 1'b0, input logic iv = 1'b1,
                       input logic fl = 1'b0, input logic wbw = 1'b0,
                       input logic [4:0] wbr = 5'd0, input logic [31:0] wbd = 32'd0);
    exp_t ee;
    ee = e;
    if (ee.valid) ee.pc = pc;
    if_valid = iv; if_instr = instr; if_pc = pc; flush = fl;
    wb_write = wbw; wb_rd = wbr; wb_data = wbd;
    #1;
    tests++;
    if (id_stall !== stall_exp) begin
      fails++;
      $display("FAIL %s_stall: id_stall=%b expected %b", nm, id_stall, stall_exp);
    end
    exp_q.push_back(ee);
    nm_q.push_back(nm);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      mn = nm_q.pop_front();
      ma = act_now();
      if (!me.valid) begin
        me.pc = '0; me.imm = '0; me.v1 = '0; me.v2 = '0;
        ma.pc = '0; ma.imm = '0; ma.v1 = '0; ma.v2 = '0;
      end
      tests++;
      if (ma !== me) begin
        fails++;
        $display("FAIL %s: ex got %h expected %h", mn, ma, me);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t addi_e, lw_e, bub;
    bub    = '0;
    addi_e = mk(32'hFFFF_FFFF, 0, 0, 0, 0, 5, A_ADD, 7'b0110000, 2'd0, 1'b0);
    lw_e   = mk(32'h0, 1, R1, 0, 0, 6, A_ADD, 7'b0111000, 2'd1, 1'b0);

    repeat (2) @(negedge clk);
    tmp = act_now();
    tests++;
    if (tmp !== '0) begin fails++; $display("FAIL reset_state: ex=%h expected 0", tmp); end
    tests++;
    if (id_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: id_stall=%b expected 0", id_stall); end
    reset = 1'b0;

    issue("addi_m1",  32'h100, 32'hFFF00293, addi_e);
    issue("sw_neg4",  32'h104, 32'hFE21AE23, mk(32'hFFFF_FFFC, 3, R1, 2, R2, 0, A_ADD, 7'b0100100, 0, 0));
    issue("beq_neg8", 32'h108, 32'hFE208CE3, mk(32'hFFFF_FFF8, 1, R1, 2, R2, 0, A_SUB, 7'b0000010, 0, 0));
    issue("lui",      32'h10C, 32'hABCD10B7, mk(32'hABCD_1000, 0, 0, 0, 0, 1, A_PASSB, 7'b0110000, 0, 0));
    issue("jal_2048", 32'h110, 32'h001000EF, mk(32'h0000_0800, 0, 0, 0, 0, 1, A_ADD, 7'b1110001, 2, 0));
    issue("byp_rs1",  32'h114, 32'h00510193, mk(32'h5, 2, 32'hABCD1234, 0, 0, 3, A_ADD, 7'b0110000, 0, 0),
          1'b0, 1'b1, 1'b0, 1'b1, 5'd2, 32'hABCD1234);
    tests++;
    if (rf_a1 !== 5'd2 || rf_a2 !== 5'd5) begin
      fails++;
      $display("FAIL rf_addr: a1=%0d a2=%0d expected 2 5", rf_a1, rf_a2);
    end
    issue("byp_wbrd0", 32'h118, 32'h00510193, mk(32'h5, 2, R1, 0, 0, 3, A_ADD, 7'b0110000, 0, 0),
          1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'hABCD1234);
    issue("byp_rs2",  32'h11C, 32'h00208233, mk(32'h0, 1, R1, 2, 32'hCAFEF00D, 4, A_ADD, 7'b0010000, 0, 0),
          1'b0, 1'b1, 1'b0, 1'b1, 5'd2, 32'hCAFEF00D);
    issue("nobyp_wbw0", 32'h120, 32'h00208233, mk(32'h0, 1, R1, 2, R2, 4, A_ADD, 7'b0010000, 0, 0),
          1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 32'hCAFEF00D);
    issue("sub",      32'h124, 32'h40208233, mk(32'h0, 1, R1, 2, R2, 4, A_SUB, 7'b0010000, 0, 0));
    issue("srai",     32'h128, 32'h4030D293, mk(32'h403, 1, R1, 0, 0, 5, A_SRA, 7'b0110000, 0, 0));
    issue("addi_nosubi", 32'h12C, 32'hC0008293, mk(32'hFFFF_FC00, 1, R1, 0, 0, 5, A_ADD, 7'b0110000, 0, 0));

    issue("lw",        32'h130, 32'h0000A303, lw_e);
    issue("lu_bubble", 32'h134, 32'h006303B3, bub, 1'b1);
    issue("lu_add",    32'h134, 32'h006303B3, mk(32'h0, 6, R1, 6, R2, 7, A_ADD, 7'b0010000, 0, 0));
    issue("lw2",       32'h138, 32'h0000A303, lw_e);
    issue("lw_lui",    32'h13C, 32'h12345337, mk(32'h1234_5000, 0, 0, 0, 0, 6, A_PASSB, 7'b0110000, 0, 0));
    issue("lw3",       32'h140, 32'h0000A303, lw_e);
    issue("lu_rs2_bubble", 32'h144, 32'h0060A023, bub, 1'b1);
    issue("lu_rs2_sw", 32'h144, 32'h0060A023, mk(32'h0, 1, R1, 6, R2, 0, A_ADD, 7'b0100100, 0, 0));
    issue("lw_x0",     32'h148, 32'h0000A003, mk(32'h0, 1, R1, 0, 0, 0, A_ADD, 7'b0111000, 1, 0));
    issue("x0_nostall", 32'h14C, 32'h000003B3, mk(32'h0, 0, 0, 0, 0, 7, A_ADD, 7'b0010000, 0, 0));
    issue("lw4",       32'h150, 32'h0000A303, lw_e);
    issue("lu_flush",  32'h154, 32'h006303B3, bub, 1'b0, 1'b1, 1'b1);
    issue("post_flush", 32'h158, 32'hFFF00293, addi_e);
    issue("lw5",       32'h15C, 32'h0000A303, lw_e);
    issue("lu_ifinvalid", 32'h160, 32'h006303B3, bub, 1'b0, 1'b0);
    issue("illegal",   32'h164, 32'h0000007F, mk(32'h0, 0, 0, 0, 0, 0, 4'd0, 7'b0000000, 0, 1));
    issue("addi_pre_rst", 32'h168, 32'hFFF00293, addi_e);

    reset = 1'b1;
    if_valid = 1'b0;
    #1;
    tests++;
    if (exb.ex_valid !== 1'b0) begin fails++; $display("FAIL async_rst_valid: ex_valid=%b expected 0", exb.ex_valid); end
    tmp = act_now();
    tests++;
    if (tmp !== '0 || id_stall !== 1'b0) begin
      fails++;
      $display("FAIL async_rst_all: ex=%h stall=%b expected 0 0", tmp, id_stall);
    end
    @(negedge clk);
    reset = 1'b0;
    issue("post_rst", 32'h16C, 32'hFFF00293, addi_e);

    if_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

RV32I instruction-decode stage with ID/EX pipeline register. It takes the fetched instruction, drives the register-file read addresses, and receives the register-file read data. It then decodes control fields and immediates and registers everything for the execute stage. It also provides write-through bypass for the register file's posedge write, load-use stall detection, and flush.

## Interface

**Parameters**
- `XLEN`, 32: datapath width. Only 32 is supported.

**Ports** (name, direction, width, meaning)
- Clock and reset (already decided): reset `reset`, asynchronous, active-high; clock `clk`.
- `if_valid`, in, 1: IF/ID holds a valid instruction.
- `if_instr`, in, 32: instruction word.
- `if_pc`, in, 32: PC of `if_instr`.
- `flush`, in, 1: taken branch/jump resolved in EX; kill the instruction currently in ID.
- `id_stall`, out, 1: combinational; fetch and IF/ID must hold.
- `rf_a1`, out, 5: register-file read address 1, equal to `if_instr[19:15]`.
- `rf_a2`, out, 5: register-file read address 2, equal to `if_instr[24:20]`.
- `rf_rs1`, in, 32: register-file read data 1.
- `rf_rs2`, in, 32: register-file read data 2.
- `wb_write`, in, 1: the writeback stage is writing the register file this cycle.
- `wb_rd`, in, 5: writeback destination register.
- `wb_data`, in, 32: writeback data.
- `ex_valid`, out, 1: ID/EX holds a valid instruction.
- `ex_pc`, out, 32; `ex_imm`, out, 32; `ex_rs1_val`, out, 32; `ex_rs2_val`, out, 32.
- `ex_rs1`, out, 5; `ex_rs2`, out, 5; `ex_rd`, out, 5; `ex_funct3`, out, 3.
- `ex_alu_ctrl`, out, 4: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
- `ex_alu_src_pc`, out, 1: ALU operand A is PC.
- `ex_alu_src_imm`, out, 1: ALU operand B is the immediate.
- `ex_reg_write`, out, 1; `ex_mem_read`, out, 1; `ex_mem_write`, out, 1; `ex_branch`, out, 1; `ex_jump`, out, 1.
- `ex_result_src`, out, 2: 0 ALU, 1 memory, 2 PC+4.
- `ex_illegal`, out, 1: unsupported opcode.

## Operation

**Supported opcodes**
- `0110011` (R-type): `alu_ctrl` from funct3/funct7[5].
- `0010011` (I-type ALU): SRAI when funct7[5]=1 on funct3=101. There is no SUBI.
- `0000011` (load): ADD, imm, `mem_read`, result 1.
- `0100011` (store): ADD, imm, `mem_write`, no `reg_write`.
- `1100011` (branch): SUB, `branch`, no `reg_write`.
- `1101111` (JAL): `alu_src_pc`, ADD, imm, `jump`, result 2.
- `1100111` (JALR): ADD, imm, `jump`, result 2.
- `0110111` (LUI): PASSB, imm.
- `0010111` (AUIPC): `alu_src_pc`, ADD, imm.

**Immediates**
- I, S, B, U, and J formats per the RV32I spec.
- All are sign-extended from `instr[31]`.
- B and J immediates have bit 0 = 0.
- U immediate is `instr[31:12]` followed by 12 zeros.

**Illegal opcode:** `ex_illegal`=1 and `ex_valid`=1, with all write/mem/branch/jump controls 0.

**Register usage**
- rs1 is used by R, I-ALU, load, store, branch, and JALR.
- rs2 is used by R, store, and branch.
- Unused source fields give `ex_rs1`/`ex_rs2` = 0.
- `ex_rd` is forced to 0 when the instruction does not write.

**Write-through bypass:** if `wb_write` and `wb_rd`≠0 and `wb_rd`==`rf_a1`, then `ex_rs1_val` captures `wb_data`; otherwise it captures `rf_rs1`. The same rule applies to rs2. A source register of x0 always yields 0.

**Load-use hazard**
- Hazard = `if_valid` && `ex_valid` && `ex_mem_read` && `ex_rd`≠0 && ((rs1 used && rs1==`ex_rd`) || (rs2 used && rs2==`ex_rd`)).
- `id_stall` = hazard && !`flush`.

**ID/EX register update** (priority order)
1. `flush`: `ex_valid`←0 and all controls ←0.
2. Hazard: insert a bubble (`ex_valid`←0 and all controls ←0). IF/ID holds, so the instruction re-decodes next cycle.
3. `if_valid`=0: bubble.
4. Otherwise: load the decoded fields, with `ex_valid`←1.

## Timing
- Reset (asynchronous): every `ex_*` output is 0. `id_stall` is 0 while reset is asserted.
- Latency: decode happens in the cycle the instruction is presented; fields appear on `ex_*` after the next rising clk edge (1 cycle).
- `rf_a1`/`rf_a2` are combinational from `if_instr`. The register-file read is assumed combinational in the same cycle.
- A load-use stall lasts exactly 1 cycle. After the bubble, `ex_mem_read`=0, so the hazard clears.
- `flush` and hazard in the same cycle: flush wins and `id_stall`=0.
- Reset deasserted mid-stream: the first edge after deassertion loads normally.
- Bubbles never assert `reg_write`, `mem_write`, `branch`, or `jump`.

## Test plan
- **Reset:** after reset, all `ex_*` are 0. Present `addi x5,x0,-1` (0xFFF00293) → `ex_imm`=0xFFFFFFFF, `ex_rd`=5, `ex_alu_ctrl`=ADD, `ex_alu_src_imm`=1, `ex_reg_write`=1.
- **Immediates:**
  - `sw x2,-4(x3)` → `ex_imm`=0xFFFFFFFC, `ex_mem_write`=1, `ex_rd`=0.
  - `beq` with offset -8 → `ex_imm`=0xFFFFFFF8.
  - `lui x1,0xABCD1` → `ex_imm`=0xABCD1000, PASSB.
  - `jal` offset +2048 → `ex_imm`=0x00000800, `ex_result_src`=2.
- **Bypass:** `rf_rs1`=0x11111111, `wb_write`=1, `wb_rd`=`rf_a1`=2, `wb_data`=0xABCD1234 → `ex_rs1_val`=0xABCD1234. With `wb_rd`=0, `ex_rs1_val`=0x11111111.
- **Load-use:** `lw x6,0(x1)` followed by `add x7,x6,x6` → `id_stall`=1 for one cycle and a bubble (`ex_valid`=0); the add then issues with `ex_rs1`=`ex_rs2`=6. A following `lui x6` produces no stall.
- **Flush:** assert `flush` during a load-use hazard → `id_stall`=0 and `ex_valid`=0 next cycle.
- **Illegal:** opcode 0x7F → `ex_illegal`=1, `ex_reg_write`=0, `ex_mem_write`=0. Asserting reset mid-stream clears `ex_valid` immediately without a clock edge.
